// File: rtl/crtc_reg_bank_pkg.sv
// crtc_reg_bank_pkg: shared constants, default tables and helpers for the CRTC register bank
package crtc_reg_bank_pkg;
  localparam int CRTC_REG_COUNT = 18;
  typedef enum logic {IDLE, RELOAD} crtc_state_e;
  localparam logic [7:0] crtc_defaults_9in [32] = '{
    0: 8'h31, 1: 8'h28, 2: 8'h29, 3: 8'h0F, 4: 8'h28, 5: 8'h05, 6: 8'h19,
    7: 8'h21, 9: 8'h07, 12: 8'h10, 13: 8'h00, default: 8'h00};
  localparam logic [7:0] crtc_defaults_12in [32] = '{
    0: 8'h31, 1: 8'h28, 2: 8'h29, 3: 8'h0F, 4: 8'h20, 5: 8'h03, 6: 8'h19,
    7: 8'h1D, 9: 8'h09, 12: 8'h10, 13: 8'h00, default: 8'h00};
  function automatic logic [4:0] wb_crtc_addr(input logic [31:0] a);
    return a[4:0];
  endfunction
  function automatic logic [7:0] crtc_default(input logic cfg, input logic [4:0] i);
    return cfg ? crtc_defaults_12in[i] : crtc_defaults_9in[i];
  endfunction
endpackage

// File: rtl/crtc_reg_bank_reload_seq.sv
// crtc_reload_seq: detects CRT size changes and walks every register through its default
module crtc_reload_seq
  import crtc_reg_bank_pkg::*;
#(
  parameter int REG_COUNT = CRTC_REG_COUNT
) (
  input  logic       wb_clock_i,
  input  logic       reset_ni,
  input  logic       config_crt_i,
  output logic       reloading_o,
  output logic       load_o,
  output logic       cfg_o,
  output logic [4:0] idx_o
);
  crtc_state_e state, state_n;
  logic [4:0] idx_n;
  logic chg;
  // state, walk index and registered config
  always_ff @(posedge wb_clock_i or negedge reset_ni)
    if (!reset_ni) begin
      state <= IDLE;
      idx_o <= '0;
      cfg_o <= config_crt_i;
    end else begin
      state <= state_n;
      idx_o <= idx_n;
      cfg_o <= config_crt_i;
    end
  // a config change (re)starts the walk at R0; otherwise RELOAD writes one register per cycle
  always_comb begin
    chg = cfg_o != config_crt_i;
    state_n = state;
    idx_n = idx_o;
    load_o = 1'b0;
    if (chg) begin
      state_n = RELOAD;
      idx_n = '0;
    end else if (state == RELOAD) begin
      load_o = 1'b1;
      idx_n = idx_o + 5'd1;
      if (int'(idx_o) == REG_COUNT - 1) begin
        state_n = IDLE;
        idx_n = '0;
      end
    end
  end
  assign reloading_o = state == RELOAD;
endmodule

// File: rtl/crtc_reg_bank.sv
// crtc_reg_bank: parametrised 6545-style register bank with Wishbone and CPU access paths
module crtc_reg_bank
  import crtc_reg_bank_pkg::*;
#(
  parameter int          REG_COUNT     = CRTC_REG_COUNT,
  parameter int          SEL_WIDTH     = 5,
  parameter int          WB_ADDR_WIDTH = 8,
  parameter int          DATA_WIDTH    = 8,
  parameter logic [31:0] READABLE_MASK = 32'h0003_C000
) (
  input  logic                     wb_clock_i,
  input  logic                     reset_ni,
  input  logic [WB_ADDR_WIDTH-1:0] wbp_addr_i,
  input  logic [DATA_WIDTH-1:0]    wbp_data_i,
  output logic [DATA_WIDTH-1:0]    wbp_data_o,
  input  logic                     wbp_we_i,
  input  logic                     wbp_cycle_i,
  input  logic                     wbp_strobe_i,
  input  logic                     wbp_sel_i,
  output logic                     wbp_stall_o,
  output logic                     wbp_ack_o,
  input  logic                     clk_en_i,
  input  logic                     cs_i,
  input  logic                     we_i,
  input  logic                     rs_i,
  input  logic [7:0]               data_i,
  output logic [7:0]               data_o,
  input  logic                     config_crt_i,
  output logic                     reloading_o,
  output logic [REG_COUNT*8-1:0]   regs_o,
  output logic [7:0]               r0_h_total_o,
  output logic [7:0]               r1_h_displayed_o,
  output logic [7:0]               r2_h_sync_pos_o,
  output logic [3:0]               r3_h_sync_width_o,
  output logic [4:0]               r3_v_sync_width_o,
  output logic [6:0]               r4_v_total_o,
  output logic [4:0]               r5_v_adjust_o,
  output logic [6:0]               r6_v_displayed_o,
  output logic [6:0]               r7_v_sync_pos_o,
  output logic [4:0]               r9_max_scan_line_o,
  output logic [13:0]              r1213_start_addr_o,
  output logic [13:0]              r1415_cursor_addr_o
);
  logic [7:0] regs [REG_COUNT];
  logic [SEL_WIDTH-1:0] sel;
  logic [4:0] wb_idx, idx;
  logic load, cfg, wb_acc, wb_in, wb_wr, cpu_act, cpu_wr, sel_in;
  crtc_reload_seq #(.REG_COUNT(REG_COUNT)) u_seq (
    .wb_clock_i(wb_clock_i), .reset_ni(reset_ni), .config_crt_i(config_crt_i),
    .reloading_o(reloading_o), .load_o(load), .cfg_o(cfg), .idx_o(idx)
  );
  assign wbp_stall_o = reloading_o;
  assign wb_idx = wb_crtc_addr(32'(wbp_addr_i));
  assign wb_acc = wbp_cycle_i & wbp_strobe_i & ~wbp_stall_o;
  assign wb_in = int'(wb_idx) < REG_COUNT;
  assign wb_wr = wb_acc & wbp_we_i & wbp_sel_i & wb_in;
  assign sel_in = int'(sel) < REG_COUNT;
  assign cpu_act = clk_en_i & cs_i;
  assign cpu_wr = cpu_act & rs_i & we_i & ~reloading_o & sel_in;
  // register storage: the CPU write lands after the Wishbone write so it wins a same-index clash
  always_ff @(posedge wb_clock_i or negedge reset_ni)
    if (!reset_ni) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= crtc_default(config_crt_i, 5'(i));
    end else begin
      if (wb_wr) regs[wb_idx] <= wbp_data_i[7:0];
      if (cpu_wr) regs[sel] <= data_i;
      if (load) regs[idx] <= crtc_default(cfg, idx);
    end
  // Wishbone ack/data one cycle after acceptance, and CPU select/read-data registers
  always_ff @(posedge wb_clock_i or negedge reset_ni)
    if (!reset_ni) begin
      wbp_ack_o <= 1'b0;
      wbp_data_o <= '0;
      sel <= '0;
      data_o <= '0;
    end else begin
      wbp_ack_o <= wb_acc;
      if (wb_acc) wbp_data_o <= (!wbp_we_i && wb_in) ? DATA_WIDTH'(regs[wb_idx]) : '0;
      if (cpu_act && !rs_i && we_i) sel <= data_i[SEL_WIDTH-1:0];
      if (cpu_act && !we_i) data_o <= (rs_i && sel_in && READABLE_MASK[sel]) ? regs[sel] : 8'h00;
    end
  for (genvar g = 0; g < REG_COUNT; g++) begin : g_flat
    assign regs_o[8*g +: 8] = regs[g];
  end
  assign r0_h_total_o = regs[0];
  assign r1_h_displayed_o = regs[1];
  assign r2_h_sync_pos_o = regs[2];
  assign r3_h_sync_width_o = regs[3][3:0];
  assign r3_v_sync_width_o = {1'b0, regs[3][7:4]};
  assign r4_v_total_o = regs[4][6:0];
  assign r5_v_adjust_o = regs[5][4:0];
  assign r6_v_displayed_o = regs[6][6:0];
  assign r7_v_sync_pos_o = regs[7][6:0];
  assign r9_max_scan_line_o = regs[9][4:0];
  assign r1213_start_addr_o = {regs[12][5:0], regs[13]};
  assign r1415_cursor_addr_o = {regs[14][5:0], regs[15]};
endmodule

// File: tb/tb_crtc_reg_bank.sv
// tb_crtc_reg_bank: scoreboard bench for the CRTC register bank
module tb_crtc_reg_bank;
  localparam int N = 18;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] waddr = '0, wdin = '0, wdat;
  logic wwe = 0, wcyc = 0, wstb = 0, wsel = 1, stall, ack;
  logic en = 0, cs = 0, wei = 0, rsi = 0, cfg = 0, reloading;
  logic [7:0] din = '0, dout;
  logic [N*8-1:0] regs;
  logic [7:0] r0, r1, r2;
  logic [3:0] r3h;
  logic [4:0] r3v, r5, r9;
  logic [6:0] r4, r6, r7;
  logic [13:0] r1213, r1415;
  typedef struct {logic rd; logic [7:0] exp; logic [7:0] idx;} sb_t;
  sb_t sb[$];
  sb_t e;
  logic [7:0] m [32];
  logic [7:0] d9 [32], d12 [32];
  logic [4:0] sm = '0;
  int checks = 0, failures = 0;

  crtc_reg_bank dut (
    .wb_clock_i(clk), .reset_ni(rst_n), .wbp_addr_i(waddr), .wbp_data_i(wdin), .wbp_data_o(wdat),
    .wbp_we_i(wwe), .wbp_cycle_i(wcyc), .wbp_strobe_i(wstb), .wbp_sel_i(wsel),
    .wbp_stall_o(stall), .wbp_ack_o(ack), .clk_en_i(en), .cs_i(cs), .we_i(wei), .rs_i(rsi),
    .data_i(din), .data_o(dout), .config_crt_i(cfg), .reloading_o(reloading), .regs_o(regs),
    .r0_h_total_o(r0), .r1_h_displayed_o(r1), .r2_h_sync_pos_o(r2), .r3_h_sync_width_o(r3h),
    .r3_v_sync_width_o(r3v), .r4_v_total_o(r4), .r5_v_adjust_o(r5), .r6_v_displayed_o(r6),
    .r7_v_sync_pos_o(r7), .r9_max_scan_line_o(r9), .r1213_start_addr_o(r1213),
    .r1415_cursor_addr_o(r1415)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n && ack) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL wb_ack unexpected ack, nothing outstanding");
      end else begin
        e = sb.pop_front();
        if (e.rd && wdat !== e.exp) begin
          failures++;
          $display("FAIL wb_read idx=%0d got=%h exp=%h", e.idx, wdat, e.exp);
        end
      end
    end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic load_model(input logic big);
    for (int i = 0; i < 32; i++) m[i] = (i < N) ? (big ? d12[i] : d9[i]) : 8'h00;
  endtask

  task automatic push(input logic we, input logic [7:0] a, input logic [7:0] d);
    sb.push_back('{rd: !we, exp: (a < N) ? m[a] : 8'h00, idx: a});
    if (we && a < N) m[a] = d;
  endtask

  task automatic wb_req(input logic we, input logic [7:0] a, input logic [7:0] d);
    int i;
    @(posedge clk); #1;
    wcyc = 1; wstb = 1; wwe = we; waddr = a; wdin = d;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!stall) break;
    end
    checks++;
    if (i == 200) begin
      failures++;
      $display("FAIL wb_stall_timeout stall=%b exp=0", stall);
    end
    push(we, a, d);
    @(posedge clk); #1;
    wcyc = 0; wstb = 0; wwe = 0;
  endtask

  task automatic wb_drain;
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL wb_drain outstanding=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic cpu(input logic rs, input logic we, input logic [7:0] d);
    @(posedge clk); #1;
    en = 1; cs = 1; rsi = rs; wei = we; din = d;
    @(posedge clk); #1;
    en = 0; cs = 0; rsi = 0; wei = 0;
    if (!rs && we) sm = d[4:0];
    if (rs && we && sm < N) m[sm] = d;
  endtask

  task automatic count_reload(output int cnt, output logic stall_bad);
    cnt = 0; stall_bad = 0;
    @(posedge clk);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!reloading) break;
      cnt++;
      if (!stall) stall_bad = 1;
    end
  endtask

  task automatic test_reset;
    cfg = 0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1;
    load_model(0);
    sm = '0;
    #1;
    checks += 7;
    if (r4 !== 7'h28) begin failures++; $display("FAIL reset_r4 got=%h exp=28", r4); end
    if (r9 !== 5'h07) begin failures++; $display("FAIL reset_r9 got=%h exp=07", r9); end
    if (reloading !== 1'b0) begin failures++; $display("FAIL reset_reloading got=%b exp=0", reloading); end
    if (dout !== 8'h00) begin failures++; $display("FAIL reset_data_o got=%h exp=00", dout); end
    if (ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", ack); end
    if (wdat !== 8'h00) begin failures++; $display("FAIL reset_wbdata got=%h exp=00", wdat); end
    if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
  endtask

  task automatic wb_burst(input logic we);
    @(posedge clk); #1;
    wcyc = 1; wstb = 1; wwe = we;
    for (int r = 0; r < N; r++) begin
      waddr = 8'(r); wdin = 8'hA0 + 8'(r);
      push(we, waddr, wdin);
      @(posedge clk); #1;
    end
    wcyc = 0; wstb = 0; wwe = 0;
  endtask

  task automatic test_back_to_back;
    wb_burst(1);
    wb_burst(0);
    wb_drain();
    checks += 3;
    if (r3v !== 5'h0A) begin failures++; $display("FAIL wb_r3v got=%h exp=0A", r3v); end
    if (r1213 !== {6'h2C, 8'hAD}) begin failures++; $display("FAIL wb_r1213 got=%h exp=%h", r1213, {6'h2C, 8'hAD}); end
    if (r0 !== 8'hA0) begin failures++; $display("FAIL wb_r0 got=%h exp=A0", r0); end
  endtask

  task automatic test_cpu;
    for (int r = 0; r < N; r++) begin
      cpu(0, 1, 8'(r));
      cpu(1, 1, 8'hB0 + 8'(r));
    end
    cpu(0, 1, 8'd14);
    cpu(1, 0, 8'h00);
    checks++;
    if (dout !== 8'hBE) begin failures++; $display("FAIL cpu_read_r14 got=%h exp=BE", dout); end
    cpu(0, 1, 8'd0);
    checks++;
    if (dout !== 8'hBE) begin failures++; $display("FAIL cpu_hold got=%h exp=BE", dout); end
    cpu(1, 0, 8'h00);
    checks++;
    if (dout !== 8'h00) begin failures++; $display("FAIL cpu_read_r0 got=%h exp=00", dout); end
    cpu(0, 1, 8'd17);
    cpu(1, 0, 8'h00);
    checks++;
    if (dout !== 8'hC1) begin failures++; $display("FAIL cpu_read_r17 got=%h exp=C1", dout); end
    cpu(0, 0, 8'h00);
    checks += 2;
    if (dout !== 8'h00) begin failures++; $display("FAIL cpu_status got=%h exp=00", dout); end
    if (r1415 !== {6'h3E, 8'hBF}) begin failures++; $display("FAIL cpu_r1415 got=%h exp=%h", r1415, {6'h3E, 8'hBF}); end
    wb_req(0, 8'd0, 8'h00);
    wb_drain();
  endtask

  task automatic same_cycle(input logic [7:0] cpu_reg, input logic [7:0] cpu_val,
                            input logic [7:0] wb_reg, input logic [7:0] wb_val);
    cpu(0, 1, cpu_reg);
    @(posedge clk); #1;
    wcyc = 1; wstb = 1; wwe = 1; waddr = wb_reg; wdin = wb_val;
    en = 1; cs = 1; rsi = 1; wei = 1; din = cpu_val;
    push(1, wb_reg, wb_val);
    m[cpu_reg] = cpu_val;
    @(posedge clk); #1;
    wcyc = 0; wstb = 0; wwe = 0; en = 0; cs = 0; rsi = 0; wei = 0;
    wb_drain();
  endtask

  task automatic test_collision;
    same_cycle(8'd1, 8'h55, 8'd1, 8'hAA);
    checks++;
    if (regs[15:8] !== 8'h55) begin failures++; $display("FAIL collide_same got=%h exp=55", regs[15:8]); end
    same_cycle(8'd2, 8'h66, 8'd3, 8'h77);
    checks += 2;
    if (regs[23:16] !== 8'h66) begin failures++; $display("FAIL collide_diff_r2 got=%h exp=66", regs[23:16]); end
    if (regs[31:24] !== 8'h77) begin failures++; $display("FAIL collide_diff_r3 got=%h exp=77", regs[31:24]); end
    wb_req(0, 8'd1, 8'h00);
    wb_drain();
  endtask

  task automatic test_reload;
    int cnt;
    logic bad;
    @(posedge clk); #1;
    cfg = 1;
    count_reload(cnt, bad);
    load_model(1);
    checks += 4;
    if (cnt != N) begin failures++; $display("FAIL reload_len got=%0d exp=%0d", cnt, N); end
    if (bad !== 1'b0) begin failures++; $display("FAIL reload_stall got=%b exp=0", bad); end
    if (r4 !== 7'h20) begin failures++; $display("FAIL reload_r4 got=%h exp=20", r4); end
    if (r7 !== 7'h1D) begin failures++; $display("FAIL reload_r7 got=%h exp=1D", r7); end
    wb_req(0, 8'd9, 8'h00);
    wb_drain();
  endtask

  task automatic test_restart;
    int cnt;
    logic bad;
    @(posedge clk); #1;
    cfg = 0;
    repeat (6) @(posedge clk);
    #1 cfg = 1;
    repeat (4) @(posedge clk);
    #1 cfg = 0;
    count_reload(cnt, bad);
    load_model(0);
    checks += 2;
    if (cnt != N) begin failures++; $display("FAIL restart_len got=%0d exp=%0d", cnt, N); end
    if (r4 !== 7'h28) begin failures++; $display("FAIL restart_r4 got=%h exp=28", r4); end
    wb_req(0, 8'd4, 8'h00);
    wb_req(0, 8'(N), 8'h00);
    wb_req(1, 8'd20, 8'hFF);
    wb_drain();
    @(posedge clk); #1;
    cfg = 1;
    wcyc = 1; wstb = 1; wwe = 0; waddr = 8'd9;
    push(0, 8'd9, 8'h00);
    @(posedge clk); #1;
    wcyc = 0; wstb = 0;
    checks++;
    if (reloading !== 1'b1) begin failures++; $display("FAIL owed_reloading got=%b exp=1", reloading); end
    wb_drain();
    load_model(1);
    wb_req(0, 8'd9, 8'h00);
    wb_drain();
    checks++;
    if (reloading !== 1'b0) begin failures++; $display("FAIL final_reloading got=%b exp=0", reloading); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin d9[i] = 8'h00; d12[i] = 8'h00; end
    d9[0] = 8'h31; d9[1] = 8'h28; d9[2] = 8'h29; d9[3] = 8'h0F; d9[4] = 8'h28; d9[5] = 8'h05;
    d9[6] = 8'h19; d9[7] = 8'h21; d9[9] = 8'h07; d9[12] = 8'h10;
    d12[0] = 8'h31; d12[1] = 8'h28; d12[2] = 8'h29; d12[3] = 8'h0F; d12[4] = 8'h20; d12[5] = 8'h03;
    d12[6] = 8'h19; d12[7] = 8'h1D; d12[9] = 8'h09; d12[12] = 8'h10;
    test_reset();
    test_back_to_back();
    test_cpu();
    test_collision();
    test_reload();
    test_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/crtc_reg_bank.md
Name: crtc_reg_bank

Overview:
- Parametrised CRTC (6545-style) register bank; successor to the fixed 16-register video CRTC register file.
- Register count and reset-default sets are parameters. The bank has two access paths:
  - a Wishbone pipelined slave, used by the management MCU;
  - a CPU bus port with register select, writes and readable cursor/light-pen registers.
- Defaults for the 9"/12" CRT are reloaded automatically whenever config_crt_i changes.
- Sits between the CPU bus decode/Wishbone interconnect and the video timing generator.

Parameters:
- REG_COUNT, 18: number of implemented registers (R0..REG_COUNT-1); legal range 16..32.
- SEL_WIDTH, 5: width of the CPU address (select) register.
- READABLE_MASK, 32'h0003_C000: bit r set means Rr is CPU-readable (default R14..R17).

Ports:
- wb_clock_i  in  1  system clock, single clock domain.
- reset_ni  in  1  asynchronous, active-low reset.
- wbp_addr_i  in  WB_ADDR_WIDTH  Wishbone address; the low SEL_WIDTH bits are the register index.
- wbp_data_i  in  DATA_WIDTH  Wishbone write data.
- wbp_data_o  out  DATA_WIDTH  Wishbone read data, valid with ack.
- wbp_we_i, wbp_cycle_i, wbp_strobe_i, wbp_sel_i  in  1 each  Wishbone pipelined controls.
- wbp_stall_o, wbp_ack_o  out  1 each  Wishbone handshake.
- clk_en_i  in  1  CPU data-strobe enable; one wb_clock_i cycle wide.
- cs_i, we_i, rs_i  in  1 each  CPU chip select, write, register select.
- data_i  in  8  CPU write data.
- data_o  out  8  CPU read data, registered.
- config_crt_i  in  1  0 = 9" defaults, 1 = 12" defaults.
- reloading_o  out  1  high while the default reload sequence runs.
- regs_o  out  REG_COUNT×8  packed raw register contents, for debug and timing decode.
- Decoded field outputs (truncation of raw values):
  - r0_h_total_o [7:0], r1_h_displayed_o [7:0], r2_h_sync_pos_o [7:0]
  - r3_h_sync_width_o = R3[3:0], r3_v_sync_width_o = {1'b0, R3[7:4]}
  - r4_v_total_o = R4[6:0], r5_v_adjust_o = R5[4:0], r6_v_displayed_o = R6[6:0], r7_v_sync_pos_o = R7[6:0]
  - r9_max_scan_line_o = R9[4:0]
  - r1213_start_addr_o = {R12[5:0], R13}
  - r1415_cursor_addr_o = {R14[5:0], R15}

Behaviour:
- Reset (reset_ni low, asynchronous):
  - all registers load the default set selected by config_crt_i;
  - select register, data_o and wbp_ack_o are 0;
  - wbp_data_o is 0;
  - FSM enters IDLE and reloading_o is 0.
- Storage is a full 8 bits per register. Truncation applies only on the decoded outputs.
- Wishbone:
  - A request is accepted when cycle&strobe&!stall.
  - wbp_ack_o is asserted exactly 1 cycle after acceptance, with wbp_data_o registered in the same cycle.
  - Back-to-back accepts give back-to-back acks.
  - Index ≥ REG_COUNT: read returns 0, write is ignored, the request is still acked.
- CPU port, evaluated only on cycles with clk_en_i && cs_i:
  - rs=0, we=1: select ← data_i[SEL_WIDTH-1:0].
  - rs=1, we=1: R[select] ← data_i if select < REG_COUNT.
  - rs=1, we=0: data_o ← R[select] if READABLE_MASK[select] and select < REG_COUNT, else 0.
  - rs=0, we=0: data_o ← 0 (status).
  - data_o holds its value until the next CPU read.
- Simultaneous writes in one cycle:
  - different registers: both writes take effect;
  - same register: the CPU write wins and the Wishbone write is dropped, but still acked.
- FSM:
  - IDLE → RELOAD on any change of the registered config_crt_i, detected one cycle after the change.
  - RELOAD walks index 0..REG_COUNT-1 at one register per cycle, writing the default value; then → IDLE. Duration is exactly REG_COUNT cycles.
  - In RELOAD: wbp_stall_o=1, CPU writes are ignored, CPU reads proceed, reloading_o=1.
  - A config_crt_i toggle during RELOAD restarts the sequence at index 0 with the new set.
  - An ack already owed for a request accepted before the stall is still delivered.
- Registers not listed in the default tables (R8, R10, R11, R14..) default to 0.

Decomposition:
- Additions to common_pkg:
  - CRTC_REG_COUNT;
  - crtc_defaults_9in and crtc_defaults_12in as 32-entry byte arrays;
  - wb_crtc_addr().
- Default values:
  - 9": R0=31 R1=28 R2=29 R3=0F R4=28 R5=05 R6=19 R7=21 R9=07 R12=10 R13=00 (hex).
  - 12": R0=31 R1=28 R2=29 R3=0F R4=20 R5=03 R6=19 R7=1D R9=09 R12=10 R13=00 (hex).
- One sub-module: crtc_reload_seq, the IDLE/RELOAD FSM, index counter and edge detect.

Test Plan:
- Reset with config_crt_i=0 → r4_v_total_o=7'h28, r9_max_scan_line_o=5'h07, reloading_o=0, data_o=0.
- Wishbone write 8'hA0+r to every r < REG_COUNT, then read back → each read returns 8'hA0+r; r3_v_sync_width_o=5'h0A; r1213_start_addr_o={6'h2C,8'hAD}.
- CPU select/write 8'hB0+r to every r, then CPU read R14 and R0 → data_o=8'hBE for R14 and 8'h00 for R0 (not readable); Wishbone read of R0=8'hB0.
- Same-cycle CPU write 8'h55 and Wishbone write 8'hAA to R1 → R1=8'h55 and the Wishbone ack is still received.
- Toggle config_crt_i to 1 → reloading_o is high for exactly REG_COUNT cycles and wbp_stall_o=1 throughout; afterwards r4_v_total_o=7'h20 and r7_v_sync_pos_o=7'h1D.
- Toggle config_crt_i back to 0 mid-reload, then wait → reload completes with 9" values (R4=8'h28); a Wishbone read of index REG_COUNT returns 0 and is acked.
